// File: rtl/itch5_msg_seq_if.sv
// itch5_msg_seq_if: MoldUDP64 payload beats in, capture-buffer enables and framing status out
interface itch5_msg_seq_if #(
    parameter int AXI_DATA_W = 64,
    parameter int LEN        = 8,
    parameter int CNT_MAX    = 7,
    parameter int MSG_LEN_W  = 6
);
    logic                  mold_v;
    logic                  mold_start;
    logic [AXI_DATA_W-1:0] mold_data;
    logic [CNT_MAX-1:0]    buf_en;
    logic                  msg_v;
    logic [LEN-1:0]        msg_type;
    logic [MSG_LEN_W-1:0]  msg_len;
    logic                  err_trunc;
    logic                  err_type;
    logic                  err_orphan;

    modport master (
        output mold_v, mold_start, mold_data,
        input  buf_en, msg_v, msg_type, msg_len, err_trunc, err_type, err_orphan
    );
    modport slave (
        input  mold_v, mold_start, mold_data,
        output buf_en, msg_v, msg_type, msg_len, err_trunc, err_type, err_orphan
    );
endinterface

// File: rtl/itch5_msg_seq.sv
// itch5_msg_seq: frames ITCH 5.0 messages from payload beats, drives capture-buffer slot enables
module itch5_msg_seq #(
    parameter int AXI_DATA_W = 64,
    parameter int LEN        = 8,
    parameter int CNT_MAX    = 7,
    parameter int CNT_MAX_W  = $clog2(CNT_MAX + 1),
    parameter int MSG_LEN_W  = 6
) (
    input logic           clk,
    input logic           nreset,
    itch5_msg_seq_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2;

    logic [1:0]           state;
    logic [CNT_MAX_W-1:0] cnt, need, need_dec, cnt_nx;
    logic [LEN-1:0]       cur_type;
    logic [MSG_LEN_W-1:0] cur_len, len_dec;
    logic [MSG_LEN_W:0]   len_sum;
    logic                 start, beat, known;

    always_comb begin
        len_dec = '0;
        case (bus.mold_data[LEN-1:0])
            8'h53, 8'h57: len_dec = MSG_LEN_W'(12);
            8'h52: len_dec = MSG_LEN_W'(39);
            8'h48: len_dec = MSG_LEN_W'(25);
            8'h59, 8'h4E: len_dec = MSG_LEN_W'(20);
            8'h4C: len_dec = MSG_LEN_W'(26);
            8'h56, 8'h4A, 8'h55: len_dec = MSG_LEN_W'(35);
            8'h4B: len_dec = MSG_LEN_W'(28);
            8'h68: len_dec = MSG_LEN_W'(21);
            8'h41, 8'h43: len_dec = MSG_LEN_W'(36);
            8'h46, 8'h51: len_dec = MSG_LEN_W'(40);
            8'h45: len_dec = MSG_LEN_W'(31);
            8'h58: len_dec = MSG_LEN_W'(23);
            8'h44, 8'h42: len_dec = MSG_LEN_W'(19);
            8'h50: len_dec = MSG_LEN_W'(44);
            8'h49: len_dec = MSG_LEN_W'(50);
            8'h4F: len_dec = MSG_LEN_W'(48);
            default: len_dec = '0;
        endcase
    end

    assign known    = len_dec != '0;
    assign len_sum  = {1'b0, len_dec} + (MSG_LEN_W + 1)'(7);
    assign need_dec = CNT_MAX_W'(len_sum >> 3);
    assign start    = bus.mold_v & bus.mold_start;
    assign beat     = bus.mold_v & ~bus.mold_start;
    assign cnt_nx   = cnt + CNT_MAX_W'(1);

    // Slot enables are combinational so the buffer captures the beat in the same cycle.
    assign bus.buf_en = (start & known) ? CNT_MAX'(1)
                      : (beat & state == RECV) ? CNT_MAX'(1) << cnt : '0;

    always_ff @(posedge clk) begin
        if (nreset) begin
            state          <= IDLE;
            cnt            <= '0;
            need           <= '0;
            cur_type       <= '0;
            cur_len        <= '0;
            bus.msg_v      <= 1'b0;
            bus.msg_type   <= '0;
            bus.msg_len    <= '0;
            bus.err_trunc  <= 1'b0;
            bus.err_type   <= 1'b0;
            bus.err_orphan <= 1'b0;
        end else begin
            bus.msg_v      <= 1'b0;
            bus.err_trunc  <= 1'b0;
            bus.err_type   <= 1'b0;
            bus.err_orphan <= 1'b0;
            if (start) begin
                bus.err_trunc <= state == RECV;
                bus.err_type  <= ~known;
                state         <= known ? RECV : DROP;
                cnt           <= known ? CNT_MAX_W'(1) : '0;
                if (known) begin
                    need     <= need_dec;
                    cur_type <= bus.mold_data[LEN-1:0];
                    cur_len  <= len_dec;
                end
            end else if (beat) begin
                if (state == RECV) begin
                    cnt <= (cnt_nx == need) ? '0 : cnt_nx;
                    if (cnt_nx == need) begin
                        state        <= IDLE;
                        bus.msg_v    <= 1'b1;
                        bus.msg_type <= cur_type;
                        bus.msg_len  <= cur_len;
                    end
                end
                bus.err_orphan <= state == IDLE;
            end
        end
    end
endmodule

// File: tb/tb_itch5_msg_seq.sv
// tb_itch5_msg_seq: directed plan plus random framing traffic against a message-level model
module tb_itch5_msg_seq;
    logic clk = 1'b0;
    logic nreset;
    int   n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    itch5_msg_seq_if #(.AXI_DATA_W(64), .LEN(8), .CNT_MAX(7), .MSG_LEN_W(6)) bus ();
    itch5_msg_seq dut (.clk(clk), .nreset(nreset), .bus(bus));

    logic [7:0] types [23] = '{8'h53, 8'h52, 8'h48, 8'h59, 8'h4C, 8'h56, 8'h57, 8'h4B, 8'h4A, 8'h68, 8'h41, 8'h46,
                               8'h45, 8'h43, 8'h58, 8'h44, 8'h55, 8'h50, 8'h51, 8'h42, 8'h49, 8'h4E, 8'h4F};
    int         lens  [23] = '{12, 39, 25, 20, 26, 35, 12, 28, 35, 21, 36, 40, 31, 36, 23, 19, 35, 44, 40, 19, 50, 20, 48};
    int         len_of [logic [7:0]];

    // Model: one message in flight, tracked by beats received versus beats its length needs.
    bit         busy, drop;
    int         got, need, m_len, out_len;
    logic [7:0] m_type, out_type;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit s, input logic [7:0] b);
        logic [6:0] e_buf;
        bit e_v, e_tr, e_ty, e_or;
        e_buf = '0;
        {e_v, e_tr, e_ty, e_or} = '0;
        nreset         = rst;
        bus.mold_v     = v;
        bus.mold_start = s;
        bus.mold_data  = {$urandom, $urandom};
        bus.mold_data[7:0] = b;
        if (rst) begin
            busy = 0; drop = 0; out_type = '0; out_len = 0;
        end else if (v && s) begin
            e_tr = busy;
            if (len_of.exists(b)) begin
                busy = 1; drop = 0; got = 1; need = (len_of[b] + 7) / 8;
                m_type = b; m_len = len_of[b]; e_buf = 7'd1;
            end else begin
                busy = 0; drop = 1; e_ty = 1;
            end
        end else if (v) begin
            if (busy) begin
                e_buf = 7'd1 << got;
                got++;
                if (got == need) begin
                    busy = 0; e_v = 1; out_type = m_type; out_len = m_len;
                end
            end else if (!drop) e_or = 1;
        end
        #1;
        check("buf_en", bus.buf_en, e_buf);
        @(posedge clk);
        #1;
        check("msg_v", bus.msg_v, e_v);
        check("err_trunc", bus.err_trunc, e_tr);
        check("err_type", bus.err_type, e_ty);
        check("err_orphan", bus.err_orphan, e_or);
        check("msg_type", bus.msg_type, out_type);
        check("msg_len", bus.msg_len, out_len);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 8'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 23; i++) len_of[types[i]] = lens[i];
        nreset = 1'b1;
        bus.mold_v = 1'b0;
        bus.mold_start = 1'b0;
        bus.mold_data = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(0, 1, 1, 8'h53); beats(1); idle(1);
        step(0, 1, 1, 8'h49); beats(3); idle(2); beats(3); idle(1);
        step(0, 1, 1, 8'h41); beats(2); step(0, 1, 1, 8'h44); beats(2); idle(1);
        step(0, 1, 1, 8'h7A); beats(3); step(0, 1, 1, 8'h53); beats(1); idle(1);
        beats(1); idle(1);
        step(0, 1, 1, 8'h50); beats(2); step(1, 0, 0, 8'h00); beats(3); idle(1);
        step(0, 1, 1, 8'h53); step(0, 1, 1, 8'h00); idle(1);
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r == 0) step(1, 0, 0, 8'h00);
            else if (r < 25) idle(1);
            else if (r < 40) step(0, 1, 1, ($urandom_range(0, 3) == 0) ? 8'($urandom) : types[$urandom_range(0, 22)]);
            else if (r < 42) step(0, 0, 1, types[$urandom_range(0, 22)]);
            else beats(1);
        end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
